genie_merge_arb: RTL and testbench

Parametrised packet-aware N-to-1 merge. It carries on from the basic merge with three additions:
- a selectable arbitration mode (round-robin or fixed priority);
- an optional two-entry output skid buffer that removes the combinational `i_ready`→`o_ready` path;
- sideband outputs reporting the source input and lock state.

It sits in generated interconnect wherever several valid/ready/eop streams converge on one sink.

---
 rtl/genie_merge_arb_if.sv | 34 +++
 rtl/genie_merge_arb.sv | 160 ++++++++++++++++
 tb/tb_genie_merge_arb.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/genie_merge_arb_if.sv
// genie_merge_arb_if: NI upstream valid/ready/eop streams plus the merged
// downstream stream and its sideband (source index, lock state).
interface genie_merge_arb_if #(
  parameter int NI    = 2,
  parameter int WIDTH = 8
);
  localparam int NIBITS = (NI > 1) ? $clog2(NI) : 1;

  // upstream side: input k occupies i_data[k*WIDTH +: WIDTH]
  logic [NI*WIDTH-1:0] i_data;
  logic [NI-1:0]       i_valid;
  logic [NI-1:0]       i_eop;
  logic [NI-1:0]       o_ready;

  // downstream side
  logic [WIDTH-1:0]    o_data;
  logic                o_valid;
  logic                o_eop;
  logic [NIBITS-1:0]   o_sel;
  logic                o_locked;
  logic                i_ready;

  // the merge block itself
  modport slave (
    input  i_data, i_valid, i_eop, i_ready,
    output o_ready, o_data, o_valid, o_eop, o_sel, o_locked
  );

  // whoever drives the sources and sinks the merged stream
  modport master (
    output i_data, i_valid, i_eop, i_ready,
    input  o_ready, o_data, o_valid, o_eop, o_sel, o_locked
  );
endinterface

// File: rtl/genie_merge_arb.sv
// genie_merge_arb: packet-aware N-to-1 merge with round-robin or fixed
// priority arbitration, optional 2-entry output skid buffer and sideband.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | no packet in flight; grant recomputed every cycle
//   S_LOCKED | multi-beat packet in flight; grant pinned to `last` until eop
module genie_merge_arb #(
  parameter int NI       = 2,
  parameter int WIDTH    = 8,
  parameter int ARB_MODE = 0,
  parameter int OUT_REG  = 1
) (
  input  logic             clk,
  input  logic             reset,
  genie_merge_arb_if.slave bus
);
  localparam int NIBITS = (NI > 1) ? $clog2(NI) : 1;
  // after reset input 0 is the first round-robin candidate
  localparam logic [NIBITS-1:0] LAST_INIT = NIBITS'(NI - 1);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [NIBITS-1:0] last;
  logic [NIBITS-1:0] grant;
  logic [NIBITS-1:0] rr_hi;
  logic [NIBITS-1:0] rr_lo;
  logic              hi_hit;
  logic              any_valid;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_valid;
  logic              sel_eop;
  logic              space;
  logic              accept;

  assign any_valid = |bus.i_valid;

  // lowest valid index above `last` (round-robin wrap point) and lowest valid overall
  always_comb begin
    rr_hi  = '0;
    rr_lo  = '0;
    hi_hit = 1'b0;
    for (int k = NI - 1; k >= 0; k--) begin
      if (bus.i_valid[k]) begin
        rr_lo = NIBITS'(k);
        if (NIBITS'(k) > last) begin
          rr_hi  = NIBITS'(k);
          hi_hit = 1'b1;
        end
      end
    end
  end

  // grant: live arbitration when idle, pinned to the packet owner when locked
  always_comb begin
    grant = last;
    if (state == S_IDLE && any_valid) begin
      if (ARB_MODE == 0 && hi_hit) grant = rr_hi;
      else                         grant = rr_lo;
    end
  end

  // mux the granted input's fields
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_eop   = 1'b0;
    for (int k = 0; k < NI; k++) begin
      if (grant == NIBITS'(k)) begin
        sel_data  = bus.i_data[k*WIDTH +: WIDTH];
        sel_valid = bus.i_valid[k];
        sel_eop   = bus.i_eop[k];
      end
    end
  end

  // o_ready[grant] && i_valid[grant] reduces to this
  assign accept = space && sel_valid;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state: lock on a non-eop first beat, unlock on the eop beat
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept && !sel_eop) state_nxt = S_LOCKED;
      S_LOCKED: if (accept && sel_eop)  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // outputs: one-hot ready on the grant (held while locked even if valid drops), lock flag
  always_comb begin
    bus.o_ready = '0;
    for (int k = 0; k < NI; k++) begin
      bus.o_ready[k] = (grant == NIBITS'(k)) && space &&
                       (state == S_LOCKED || sel_valid);
    end
    bus.o_locked = (state == S_LOCKED);
  end

  // remember the most recently served input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last <= LAST_INIT;
    else if (accept) last <= grant;
  end

  if (OUT_REG != 0) begin : g_skid
    localparam int EW = NIBITS + 1 + WIDTH;

    logic [EW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;

    // space is purely registered so i_ready never reaches o_ready
    assign space = (count != 2'd2);
    assign push  = accept;
    assign pop   = (count != 2'd0) && bus.i_ready;

    // two-entry FIFO of {sel, eop, data}
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        mem[0] <= '0;
        mem[1] <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {grant, sel_eop, sel_data};
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end

    assign bus.o_valid = (count != 2'd0);
    assign {bus.o_sel, bus.o_eop, bus.o_data} = mem[rd_ptr];
  end else begin : g_pass
    assign space       = bus.i_ready;
    assign bus.o_valid = sel_valid;
    assign bus.o_data  = sel_data;
    assign bus.o_eop   = sel_eop;
    assign bus.o_sel   = grant;
  end
endmodule

// File: tb/tb_genie_merge_arb.sv
// tb_genie_merge_arb: five merge configurations driven from one shared random
// stimulus and compared every cycle against a queue-based reference model.
module tb_genie_merge_arb;
  localparam int ND = 5;
  localparam int CFG_NI   [ND] = '{4, 4, 3, 5, 1};
  localparam int CFG_MODE [ND] = '{0, 1, 0, 0, 0};
  localparam int CFG_OREG [ND] = '{1, 1, 0, 1, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  stim_valid;
  logic [4:0]  stim_eop;
  logic [39:0] stim_data;
  logic [ND-1:0] stim_rdy;

  logic [4:0] obs_ready  [ND];
  logic [7:0] obs_data   [ND];
  logic       obs_valid  [ND];
  logic       obs_eop    [ND];
  logic [2:0] obs_sel    [ND];
  logic       obs_locked [ND];

  int n_chk = 0;
  int n_err = 0;

  // reference model state: entry = sel*512 + eop*256 + data
  int m_last   [ND];
  bit m_locked [ND];
  int m_q      [ND][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int GNI = CFG_NI[g];
    genie_merge_arb_if #(.NI(GNI), .WIDTH(8)) bus ();
    assign bus.i_data  = stim_data[GNI*8-1:0];
    assign bus.i_valid = stim_valid[GNI-1:0];
    assign bus.i_eop   = stim_eop[GNI-1:0];
    assign bus.i_ready = stim_rdy[g];
    genie_merge_arb #(
      .NI(GNI), .WIDTH(8), .ARB_MODE(CFG_MODE[g]), .OUT_REG(CFG_OREG[g])
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
    assign obs_ready[g]  = 5'(bus.o_ready);
    assign obs_data[g]   = bus.o_data;
    assign obs_valid[g]  = bus.o_valid;
    assign obs_eop[g]    = bus.o_eop;
    assign obs_sel[g]    = 3'(bus.o_sel);
    assign obs_locked[g] = bus.o_locked;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic string tg(input int d, input string s);
    return $sformatf("dut%0d_%s", d, s);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_last[d]   = CFG_NI[d] - 1;
      m_locked[d] = 1'b0;
      m_q[d].delete();
    end
  endtask

  // which input the arbiter picks this cycle, by scanning the rule directly
  function automatic int model_grant(input int d);
    int n;
    int res;
    bit found;
    n = CFG_NI[d];
    res = m_last[d];
    found = 1'b0;
    if (!m_locked[d]) begin
      if (CFG_MODE[d] == 1) begin
        for (int k = 0; k < n; k++)
          if (!found && stim_valid[k]) begin res = k; found = 1'b1; end
      end else begin
        for (int off = 1; off <= n; off++) begin
          int k;
          k = (m_last[d] + off) % n;
          if (!found && stim_valid[k]) begin res = k; found = 1'b1; end
        end
      end
    end
    return res;
  endfunction

  task automatic check_and_step(input bit in_reset);
    for (int d = 0; d < ND; d++) begin
      int g;
      int head;
      bit space;
      bit ev;
      bit acc;
      logic [4:0] er;
      g = model_grant(d);
      space = (CFG_OREG[d] != 0) ? (m_q[d].size() < 2) : stim_rdy[d];
      er = (space && (m_locked[d] || stim_valid[g])) ? 5'(1 << g) : 5'd0;
      chk(tg(d, "ready"), 32'(obs_ready[d]), 32'(er));
      chk(tg(d, "locked"), 32'(obs_locked[d]), 32'(m_locked[d]));
      if (CFG_OREG[d] != 0) begin
        ev = (m_q[d].size() != 0);
        chk(tg(d, "valid"), 32'(obs_valid[d]), 32'(ev));
        if (ev) begin
          head = m_q[d][0];
          chk(tg(d, "data"), 32'(obs_data[d]), 32'(head & 255));
          chk(tg(d, "eop"), 32'(obs_eop[d]), 32'((head >> 8) & 1));
          chk(tg(d, "sel"), 32'(obs_sel[d]), 32'(head >> 9));
        end else if (in_reset) begin
          chk(tg(d, "rst_data"), 32'(obs_data[d]), 32'd0);
          chk(tg(d, "rst_eop"), 32'(obs_eop[d]), 32'd0);
          chk(tg(d, "rst_sel"), 32'(obs_sel[d]), 32'd0);
        end
      end else begin
        chk(tg(d, "valid"), 32'(obs_valid[d]), 32'(stim_valid[g]));
        chk(tg(d, "data"), 32'(obs_data[d]), 32'(stim_data[g*8 +: 8]));
        chk(tg(d, "eop"), 32'(obs_eop[d]), 32'(stim_eop[g]));
        chk(tg(d, "sel"), 32'(obs_sel[d]), 32'(g));
      end
      if (!in_reset) begin
        acc = (er != 5'd0) && stim_valid[g];
        if (CFG_OREG[d] != 0 && m_q[d].size() != 0 && stim_rdy[d])
          void'(m_q[d].pop_front());
        if (acc) begin
          if (CFG_OREG[d] != 0)
            m_q[d].push_back(g * 512 + int'(stim_eop[g]) * 256 + int'(stim_data[g*8 +: 8]));
          m_last[d] = g;
          if (!m_locked[d] && !stim_eop[g])     m_locked[d] = 1'b1;
          else if (m_locked[d] && stim_eop[g]) m_locked[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic zero_stim();
    stim_valid = '0;
    stim_eop   = '0;
    stim_data  = '0;
    stim_rdy   = '1;
  endtask

  task automatic drive(input int pv, input int pe, input int pr);
    for (int k = 0; k < 5; k++) begin
      stim_valid[k] = (int'($urandom_range(99)) < pv);
      stim_eop[k]   = (int'($urandom_range(99)) < pe);
      stim_data[k*8 +: 8] = 8'($urandom);
    end
    for (int d = 0; d < ND; d++) stim_rdy[d] = (int'($urandom_range(99)) < pr);
  endtask

  task automatic run(input int n, input int pv, input int pe, input int pr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      drive(pv, pe, pr);
      #1;
      check_and_step(1'b0);
    end
  endtask

  // reset asserted between edges, outputs checked while held
  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
      reset = 1'b0;
      zero_stim();
      model_reset();
      #1;
      check_and_step(1'b1);
    end
  endtask

  initial begin
    reset = 1'b1;
    zero_stim();
    model_reset();
    #1 reset = 1'b0;
    reset_cycles(3);
    // all inputs valid with single-beat packets: round-robin rotation
    run(12, 100, 100, 100);
    run(300, 60, 30, 70);
    // sink stalled with streaming inputs, then drained
    run(6, 100, 20, 0);
    run(8, 100, 20, 100);
    run(300, 30, 50, 50);
    // build up locked packets, then reset in the middle of them
    run(7, 100, 10, 100);
    reset_cycles(2);
    run(10, 100, 100, 100);
    run(300, 80, 40, 30);
    run(200, 90, 15, 90);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
